// File: rtl/cpu_pipe_pkg.sv
// Shared constants for CPU datapath staging blocks.
package cpu_pipe_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] RESET_VAL_DEF = '0;

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a data word with load/hold/clear control.
module pipe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Clear wins over load; data only moves with a real item, so bubbles keep the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, flush, freeze and occupancy.
module elastic_pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH:0]   r;
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  assign r[DEPTH] = out_ready;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_data;

      if (i == 0) begin : g_head
        assign up_valid = in_valid;
        assign up_data  = in_data;
      end else begin : g_body
        assign up_valid = v[i-1];
        assign up_data  = d[i-1];
      end

      // rst in the chain keeps in_ready low while the block is held in reset.
      assign r[i] = rst & ena & ~flush & (~v[i] | r[i+1]);

      pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .load     (r[i]),
        .up_valid (up_valid),
        .up_data  (up_data),
        .valid    (v[i]),
        .data     (d[i])
      );
    end
  endgenerate

  assign in_ready  = r[0];
  assign out_valid = v[DEPTH-1] & ena & ~flush;
  assign out_data  = d[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg (DEPTH=2 and DEPTH=3 instances on shared stimulus).
module tb_elastic_pipe_reg;

  localparam logic [31:0] RV2 = 32'hA5A5_A5A5;
  localparam logic [31:0] RV3 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = 32'h0;

  logic        ir2, ov2, ir3, ov3;
  logic [31:0] od2, od3;
  logic [1:0]  oc2, oc3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(2), .RESET_VAL(RV2)) u_dut2 (
    .clk(clk), .rst(rst), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_ready(out_ready), .occupancy(oc2)
  );

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV3)) u_dut3 (
    .clk(clk), .rst(rst), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_ready(out_ready), .occupancy(oc3)
  );

  // Reference model: k=0 is the DEPTH=2 instance, k=1 the DEPTH=3 instance.
  bit          mv [2][3];
  logic [31:0] md [2][3];

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++) begin
        mv[k][i] = 1'b0;
        md[k][i] = (k == 0) ? RV2 : RV3;
      end
  endtask

  // Everything at or below the highest hole (or the whole pipe when out_ready) shifts one slot.
  task automatic model_step(int k);
    int dpt;
    int g;
    int top;
    dpt = k + 2;
    if (flush) begin
      for (int i = 0; i < dpt; i++) mv[k][i] = 1'b0;
      return;
    end
    if (!ena) return;
    g = -1;
    if (out_ready) g = dpt;
    else for (int i = 0; i < dpt; i++) if (!mv[k][i]) g = i;
    if (g < 0) return;
    top = (g >= dpt) ? dpt - 1 : g;
    for (int i = top; i >= 1; i--) begin
      mv[k][i] = mv[k][i-1];
      if (mv[k][i-1]) md[k][i] = md[k][i-1];
    end
    mv[k][0] = in_valid;
    if (in_valid) md[k][0] = in_data;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare(int k, logic a_ir, logic a_ov, logic [31:0] a_od, logic [1:0] a_oc);
    int dpt;
    int cnt;
    bit hole;
    dpt = k + 2;
    cnt = 0;
    hole = 1'b0;
    for (int i = 0; i < dpt; i++) begin
      cnt += mv[k][i] ? 1 : 0;
      if (!mv[k][i]) hole = 1'b1;
    end
    check($sformatf("model_in_ready[%0d]", k), {31'b0, a_ir},
          {31'b0, rst & ena & ~flush & (out_ready | hole)});
    check($sformatf("model_out_valid[%0d]", k), {31'b0, a_ov},
          {31'b0, rst & mv[k][dpt-1] & ena & ~flush});
    check($sformatf("model_out_data[%0d]", k), a_od, md[k][dpt-1]);
    check($sformatf("model_occupancy[%0d]", k), {30'b0, a_oc}, cnt);
  endtask

  always @(negedge clk) begin
    model_compare(0, ir2, ov2, od2, oc2);
    model_compare(1, ir3, ov3, od3, oc3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a pending item
    rst = 1'b0; in_valid = 1'b1; in_data = 32'h77; ena = 1'b1; out_ready = 1'b1;
    repeat (2) tick();
    check("rst_out_valid2", {31'b0, ov2}, 32'd0);
    check("rst_in_ready2", {31'b0, ir2}, 32'd0);
    check("rst_occ2", {30'b0, oc2}, 32'd0);
    check("rst_out_data2", od2, RV2);
    check("rst_out_data3", od3, RV3);
    rst = 1'b1; in_data = 32'd1;
    #1;
    check("release_in_ready2", {31'b0, ir2}, 32'd1);
    check("release_in_ready3", {31'b0, ir3}, 32'd1);

    // Streaming 1..6
    for (int n = 1; n <= 6; n++) begin
      in_data = n;
      tick();
      if (n >= 2) begin
        check("stream_valid2", {31'b0, ov2}, 32'd1);
        check("stream_data2", od2, n - 1);
      end
      if (n >= 3) check("stream_data3", od3, n - 2);
    end

    // Backpressure
    out_ready = 1'b0; in_data = 32'd7;
    repeat (5) tick();
    check("bp_occ2", {30'b0, oc2}, 32'd2);
    check("bp_in_ready2", {31'b0, ir2}, 32'd0);
    check("bp_data2", od2, 32'd5);
    check("bp_occ3", {30'b0, oc3}, 32'd3);
    check("bp_data3", od3, 32'd4);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_data = 7 + j;
      tick();
      check("drain_valid2", {31'b0, ov2}, 32'd1);
      check("drain_data2", od2, 6 + j);
      check("drain_data3", od3, 5 + j);
    end

    // Bubble collapse
    in_valid = 1'b0;
    repeat (4) tick();
    check("empty_occ3", {30'b0, oc3}, 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 32'hB; tick();
    in_valid = 1'b0; tick();
    check("bubble_occ3", {30'b0, oc3}, 32'd2);
    check("bubble_data3", od3, 32'hA);
    check("bubble_valid3", {31'b0, ov3}, 32'd1);
    in_valid = 1'b1; in_data = 32'hC; tick();
    check("bubble_full_occ3", {30'b0, oc3}, 32'd3);
    check("bubble_full_ready3", {31'b0, ir3}, 32'd0);
    check("bubble_occ2", {30'b0, oc2}, 32'd2);

    // Flush with an item on the input
    flush = 1'b1; in_data = 32'hF; out_ready = 1'b1;
    #1;
    check("flush_out_valid2", {31'b0, ov2}, 32'd0);
    check("flush_in_ready2", {31'b0, ir2}, 32'd0);
    check("flush_out_valid3", {31'b0, ov3}, 32'd0);
    check("flush_in_ready3", {31'b0, ir3}, 32'd0);
    tick();
    flush = 1'b0;
    check("flush_occ2", {30'b0, oc2}, 32'd0);
    check("flush_occ3", {30'b0, oc3}, 32'd0);

    // Freeze
    in_data = 32'h21; tick();
    in_data = 32'h22; tick();
    check("pre_freeze_data2", od2, 32'h21);
    ena = 1'b0; in_data = 32'h23;
    #1;
    check("freeze_out_valid2", {31'b0, ov2}, 32'd0);
    check("freeze_in_ready2", {31'b0, ir2}, 32'd0);
    repeat (3) begin
      tick();
      check("freeze_hold_valid2", {31'b0, ov2}, 32'd0);
      check("freeze_hold_occ2", {30'b0, oc2}, 32'd2);
      check("freeze_hold_data2", od2, 32'h21);
      check("freeze_hold_occ3", {30'b0, oc3}, 32'd2);
    end
    ena = 1'b1;
    #1;
    check("thaw_valid2", {31'b0, ov2}, 32'd1);
    check("thaw_data2", od2, 32'h21);

    // Asynchronous reset between edges
    in_data = 32'h24; tick();
    #2 rst = 1'b0;
    #1;
    check("async_rst_occ2", {30'b0, oc2}, 32'd0);
    check("async_rst_occ3", {30'b0, oc3}, 32'd0);
    check("async_rst_valid2", {31'b0, ov2}, 32'd0);
    check("async_rst_ready2", {31'b0, ir2}, 32'd0);
    check("async_rst_data2", od2, RV2);
    @(posedge clk);
    #2 rst = 1'b1; in_valid = 1'b0;
    repeat (3) begin
      tick();
      check("no_stale_valid2", {31'b0, ov2}, 32'd0);
      check("no_stale_valid3", {31'b0, ov3}, 32'd0);
    end
    in_valid = 1'b1; in_data = 32'h31; tick();
    in_valid = 1'b0; tick();
    check("recover_valid2", {31'b0, ov2}, 32'd1);
    check("recover_data2", od2, 32'h31);
    tick();
    check("recover_valid3", {31'b0, ov3}, 32'd1);
    check("recover_data3", od3, 32'h31);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
